// File: rtl/rail_fence_encrypt.sv
// rail_fence_encrypt
//   Buffers a plaintext message (terminated by TERM or by filling MAX_LEN
//   bytes), then emits it rail-fence encrypted with 1, 2 or 3 rails, followed
//   by a single TERM byte flagged with done.
//
// Ports
//   clk      : clock, all state on rising edge
//   reset    : asynchronous, active-high reset
//   data     : plaintext byte
//   valid_i  : data qualifier (ignored while busy)
//   key      : rail count, 2'b11 = 3, 2'b10 = 2, else 1 (pass-through)
//   ready_i  : downstream accepts data_c
//   data_c   : ciphertext byte (registered)
//   valid_o  : data_c qualifier (registered)
//   busy     : high while emitting / flushing; input not accepted
//   done     : high together with the trailing TERM byte
module rail_fence_encrypt #(
  parameter int         MAX_LEN = 50,
  parameter logic [7:0] TERM    = 8'hFA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid_i,
  input  logic [1:0] key,
  input  logic       ready_i,
  output logic [7:0] data_c,
  output logic       valid_o,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, FLUSH} state_t;

  localparam logic [5:0] LAST_IDX = 6'(MAX_LEN - 1);
  localparam logic [6:0] FULL_LEN = 7'(MAX_LEN);

  state_t     state;
  logic [7:0] buffer [MAX_LEN];
  logic [5:0] len;
  logic [1:0] key_r;
  logic [1:0] rail;
  logic [5:0] idx;
  logic [5:0] cnt;     // ciphertext bytes already placed on data_c

  // ---------------------------------------------------------------------
  // Rail geometry from the latched key
  // ---------------------------------------------------------------------
  logic [1:0] n_rails;
  logic [2:0] period;

  always_comb begin
    n_rails = 2'd1;
    period  = 3'd1;
    case (key_r)
      2'b11:   begin n_rails = 2'd3; period = 3'd4; end
      2'b10:   begin n_rails = 2'd2; period = 3'd2; end
      default: begin n_rails = 2'd1; period = 3'd1; end
    endcase
  end

  // Outer rails visit one index per period; the middle rail of a 3-rail
  // fence hits both i%4==1 and i%4==3, i.e. every second index.
  logic [2:0] step;
  logic [6:0] idx_step;
  logic [1:0] next_rail;
  logic [5:0] next_idx;

  always_comb begin
    step      = (rail == 2'd0 || rail == n_rails - 2'd1) ? period : 3'd2;
    idx_step  = {1'b0, idx} + {4'd0, step};
    next_rail = rail;
    next_idx  = idx_step[5:0];
    if (idx_step >= {1'b0, len}) begin
      // Rail exhausted: next rail starts at its own number. A rail whose
      // start lies past len is never emitted because cnt reaches len first.
      next_rail = rail + 2'd1;
      next_idx  = {4'd0, rail} + 6'd1;
    end
  end

  // Keep the read address inside the buffer even for indices that are
  // computed but never consumed.
  logic [5:0] rd_idx;
  assign rd_idx = (idx > LAST_IDX) ? 6'd0 : idx;

  // ---------------------------------------------------------------------
  // Message buffer (no reset; stale contents are never read)
  // ---------------------------------------------------------------------
  logic       wr_en;
  logic [5:0] wr_idx;

  always_comb begin
    wr_en  = valid_i && (data != TERM) && (state == IDLE || state == LOAD);
    wr_idx = (state == IDLE) ? 6'd0 : len;
    if (wr_idx > LAST_IDX) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) buffer[wr_idx] <= data;
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      len     <= '0;
      key_r   <= '0;
      rail    <= '0;
      idx     <= '0;
      cnt     <= '0;
      data_c  <= '0;
      valid_o <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A lone TERM in IDLE is an empty message and is dropped.
          if (valid_i && data != TERM) begin
            len   <= 6'd1;
            key_r <= key;
            rail  <= '0;
            idx   <= '0;
            cnt   <= '0;
            state <= (FULL_LEN == 7'd1) ? EMIT : LOAD;
          end
        end

        LOAD: begin
          if (valid_i) begin
            if (data == TERM) begin
              state <= EMIT;
            end else begin
              len <= len + 6'd1;
              if (({1'b0, len} + 7'd1) == FULL_LEN) state <= EMIT;
            end
            rail <= '0;
            idx  <= '0;
            cnt  <= '0;
          end
        end

        EMIT: begin
          // Load a new byte when the output register is empty or is
          // transferring this edge; otherwise hold data_c/valid_o.
          if (!valid_o || ready_i) begin
            if (cnt != len) begin
              data_c  <= buffer[rd_idx];
              valid_o <= 1'b1;
              cnt     <= cnt + 6'd1;
              rail    <= next_rail;
              idx     <= next_idx;
            end else begin
              data_c  <= TERM;
              valid_o <= 1'b1;
              done    <= 1'b1;
              state   <= FLUSH;
            end
          end
        end

        FLUSH: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            done    <= 1'b0;
            len     <= '0;
            rail    <= '0;
            idx     <= '0;
            cnt     <= '0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == EMIT) || (state == FLUSH);

endmodule

// File: tb/tb_rail_fence_encrypt.sv
module tb_rail_fence_encrypt;
  localparam int         MAX_LEN = 50;
  localparam logic [7:0] TERM    = 8'hFA;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data;
  logic       valid_i;
  logic [1:0] key;
  logic       ready_i;
  logic [7:0] data_c;
  logic       valid_o;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rail_fence_encrypt #(.MAX_LEN(MAX_LEN), .TERM(TERM)) dut (
    .clk(clk), .reset(reset), .data(data), .valid_i(valid_i), .key(key),
    .ready_i(ready_i), .data_c(data_c), .valid_o(valid_o), .busy(busy),
    .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: rail r takes every index i with i mod P in {r, P-r}, in order.
  function automatic void rail_model(input logic [7:0] msg[$], input logic [1:0] k,
                                     output logic [7:0] exp[$]);
    int n = (k == 2'b11) ? 3 : (k == 2'b10) ? 2 : 1;
    int p = (n == 1) ? 1 : 2 * (n - 1);
    exp.delete();
    for (int r = 0; r < n; r++)
      for (int i = 0; i < msg.size(); i++)
        if ((i % p) == r || (i % p) == (p - r)) exp.push_back(msg[i]);
  endfunction

  function automatic void str2q(input string s, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  // Inputs change on negedges; key is scrambled after the first byte.
  task automatic send(input logic [7:0] msg[$], input logic [1:0] k0, input bit term);
    for (int i = 0; i < msg.size(); i++) begin
      chk("busy_low_while_loading", busy, 0);
      data    = msg[i];
      valid_i = 1'b1;
      key     = (i == 0) ? k0 : 2'($urandom);
      @(negedge clk);
    end
    if (term) begin
      chk("busy_low_before_term", busy, 0);
      data    = TERM;
      valid_i = 1'b1;
      key     = 2'($urandom);
      @(negedge clk);
    end
    valid_i = 1'b0;
  endtask

  task automatic drive_junk();
    valid_i = 1'b1;
    data    = ($urandom_range(0, 3) == 0) ? TERM : 8'($urandom);
    key     = 2'($urandom);
  endtask

  // Called at the negedge right after the edge that entered EMIT.
  task automatic collect(input logic [7:0] exp[$], input int stall_first,
                         input bit rand_ready, input bit junk);
    int k = 0;
    int cyc = 0;
    int stall_left = stall_first;
    bit started = 0;
    int n = exp.size();
    chk("emit_entry_valid_low", valid_o, 0);
    chk("emit_entry_busy", busy, 1);
    ready_i = 1'b1;
    if (junk) drive_junk();
    while (k <= n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (junk) drive_junk();
      if (cyc == 1) chk("first_valid_latency", valid_o, 1);
      if (valid_o === 1'b1) begin
        started = 1;
        if (k < n) begin
          chk($sformatf("cipher_byte[%0d]", k), data_c, exp[k]);
          chk("done_low_mid_msg", done, 0);
        end else begin
          chk("term_byte", data_c, TERM);
          chk("done_with_term", done, 1);
        end
        chk("busy_while_emitting", busy, 1);
        if (k == 0 && stall_left > 0) begin
          ready_i = 1'b0;
          stall_left--;
        end else begin
          ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (ready_i) k++;
      end else if (started) begin
        chk("no_gap_in_output", valid_o, 1);
      end
    end
    if (k <= n) chk("collect_timeout_bytes", k, n + 1);
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    chk("idle_valid_low", valid_o, 0);
    chk("idle_done_low", done, 0);
    chk("idle_busy_low", busy, 0);
  endtask

  initial begin
    logic [7:0] msg[$];
    logic [7:0] exp[$];
    logic [1:0] k;
    int         len;

    reset = 1'b1; valid_i = 1'b0; data = '0; key = '0; ready_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_data_c", data_c, 0);
    chk("reset_valid_o", valid_o, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Stray TERM while idle must not start a message.
    data = TERM; valid_i = 1'b1; @(negedge clk); valid_i = 1'b0;
    chk("term_in_idle_ignored", busy, 0);

    // HELLO, 2 rails
    str2q("HELLO", msg); rail_model(msg, 2'b10, exp);
    send(msg, 2'b10, 1); collect(exp, 0, 0, 0);

    // ABCDEFG, 3 rails
    str2q("ABCDEFG", msg); rail_model(msg, 2'b11, exp);
    send(msg, 2'b11, 1); collect(exp, 0, 0, 0);

    // AB, 3 rails: last rail skipped with no gap
    str2q("AB", msg); rail_model(msg, 2'b11, exp);
    send(msg, 2'b11, 1); collect(exp, 0, 0, 0);

    // single byte, 3 rails
    str2q("X", msg); rail_model(msg, 2'b11, exp);
    send(msg, 2'b11, 1); collect(exp, 0, 0, 0);

    // Full buffer without TERM, junk input during EMIT/FLUSH
    msg.delete();
    for (int i = 0; i < MAX_LEN; i++) msg.push_back(8'(i));
    rail_model(msg, 2'b10, exp);
    send(msg, 2'b10, 0); collect(exp, 0, 0, 1);

    // Back-pressure on the first byte
    str2q("HELLO", msg); rail_model(msg, 2'b10, exp);
    send(msg, 2'b10, 1); collect(exp, 3, 0, 0);

    // Reset in the middle of EMIT
    send(msg, 2'b10, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_valid_o", valid_o, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_data_c", data_c, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    str2q("AB", msg); rail_model(msg, 2'b10, exp);
    send(msg, 2'b10, 1); collect(exp, 0, 0, 0);

    // Randomized messages with random back-pressure
    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(1, MAX_LEN);
      if (t == 0) len = MAX_LEN;
      k = 2'($urandom);
      msg.delete();
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == TERM) b = 8'h00;
        msg.push_back(b);
      end
      rail_model(msg, k, exp);
      send(msg, k, len < MAX_LEN);
      collect(exp, $urandom_range(0, 2), 1, t[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
